// File: rtl/coder_pkg.sv
// Shared types for the serial index coder.
package coder_pkg;

    // Serialiser FSM: waiting for a vector, or emitting its indices.
    typedef enum logic {
        CODER_IDLE = 1'b0,
        CODER_EMIT = 1'b1
    } coder_state_e;

endpackage

// File: rtl/prio_coder_n.sv
// Parametrised priority encoder: reports the lowest (or highest) set bit,
// whether exactly one bit is set, and whether the vector is empty.
module prio_coder_n #(
    parameter  int unsigned DATA_W    = 8,
    parameter  bit          MSB_FIRST = 1'b0,
    localparam int unsigned IDX_W     = $clog2(DATA_W)
) (
    input  logic [DATA_W-1:0] data,
    output logic [IDX_W-1:0]  index,
    output logic              one_left,
    output logic              empty
);

    logic        found;
    int unsigned sel;

    // Scan in emission order; the first set bit encountered wins.
    always_comb begin
        index = '0;
        found = 1'b0;
        sel   = 0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            sel = MSB_FIRST ? (DATA_W - 1 - i) : i;
            if (!found && data[sel]) begin
                index = IDX_W'(sel);
                found = 1'b1;
            end
        end
    end

    // Exactly one bit set: non-empty and clearing the lowest set bit leaves zero.
    always_comb begin
        empty    = ~|data;
        one_left = !empty && ((data & (data - DATA_W'(1))) == '0);
    end

endmodule

// File: rtl/coder_serial.sv
// Serial index coder: accepts a request vector and emits the index of every
// set bit, one beat per output handshake, in ascending or descending order.
module coder_serial
    import coder_pkg::*;
#(
    parameter  int unsigned DATA_W    = 8,
    parameter  bit          MSB_FIRST = 1'b0,
    localparam int unsigned IDX_W     = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [IDX_W-1:0]  q_o,
    output logic              q_valid_o,
    input  logic              q_ready_i,
    output logic              q_last_o,
    output logic              q_none_o
);

    coder_state_e      state;
    coder_state_e      state_next;
    logic [DATA_W-1:0] pending;
    logic [DATA_W-1:0] clr_bit;
    logic [IDX_W-1:0]  sel_index;
    logic              sel_one_left;
    logic              sel_empty;
    logic              out_hs;

    prio_coder_n #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_prio (
        .data     (pending),
        .index    (sel_index),
        .one_left (sel_one_left),
        .empty    (sel_empty)
    );

    // One-hot of the bit being emitted, used to retire it from the mask.
    always_comb begin
        clr_bit = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            clr_bit[i] = (IDX_W'(i) == sel_index);
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= CODER_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pending mask: load on acceptance, retire one bit per output handshake.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pending <= '0;
        end else if (state == CODER_IDLE && valid_i) begin
            pending <= data_i;
        end else if (out_hs) begin
            pending <= pending & ~clr_bit;
        end
    end

    // Next-state logic; an all-zero vector leaves after its single beat.
    always_comb begin
        state_next = state;
        unique case (state)
            CODER_IDLE: if (valid_i) state_next = CODER_EMIT;
            CODER_EMIT: if (q_ready_i && (sel_one_left || sel_empty)) state_next = CODER_IDLE;
            default:    state_next = CODER_IDLE;
        endcase
    end

    // Outputs decoded from the state register and the pending mask only.
    always_comb begin
        ready_o   = (state == CODER_IDLE);
        q_valid_o = (state == CODER_EMIT);
        out_hs    = q_valid_o && q_ready_i;
        q_o       = q_valid_o ? sel_index : '0;
        q_last_o  = q_valid_o && (sel_one_left || sel_empty);
        q_none_o  = q_valid_o && sel_empty;
    end

endmodule

// File: tb/tb_coder_serial.sv
// Directed bench for coder_serial: LSB-first and MSB-first 8-bit instances
// plus a 13-bit instance, all sharing clock and reset.
module tb_coder_serial;

    logic clk = 1'b0;
    logic rst_n;

    logic [7:0]  data_a, data_b;
    logic [12:0] data_c;
    logic        valid_a, valid_b, valid_c;
    logic        qr_a, qr_b, qr_c;
    logic        rdy_a, rdy_b, rdy_c;
    logic [2:0]  q_a, q_b;
    logic [3:0]  q_c;
    logic        qv_a, qv_b, qv_c;
    logic        last_a, last_b, last_c;
    logic        none_a, none_b, none_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    coder_serial #(.DATA_W(8), .MSB_FIRST(1'b0)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .data_i(data_a), .valid_i(valid_a),
        .ready_o(rdy_a), .q_o(q_a), .q_valid_o(qv_a), .q_ready_i(qr_a),
        .q_last_o(last_a), .q_none_o(none_a)
    );

    coder_serial #(.DATA_W(8), .MSB_FIRST(1'b1)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .data_i(data_b), .valid_i(valid_b),
        .ready_o(rdy_b), .q_o(q_b), .q_valid_o(qv_b), .q_ready_i(qr_b),
        .q_last_o(last_b), .q_none_o(none_b)
    );

    coder_serial #(.DATA_W(13), .MSB_FIRST(1'b0)) dut_c (
        .clk_i(clk), .rst_n_i(rst_n), .data_i(data_c), .valid_i(valid_c),
        .ready_o(rdy_c), .q_o(q_c), .q_valid_o(qv_c), .q_ready_i(qr_c),
        .q_last_o(last_c), .q_none_o(none_c)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat_a(input string tag, input int eq, input int elast, input int enone);
        chk({tag, "_valid"}, 32'(qv_a), 1);
        chk({tag, "_q"},     32'(q_a), 32'(eq));
        chk({tag, "_last"},  32'(last_a), 32'(elast));
        chk({tag, "_none"},  32'(none_a), 32'(enone));
        chk({tag, "_ready"}, 32'(rdy_a), 0);
    endtask

    task automatic beat_b(input string tag, input int eq, input int elast);
        chk({tag, "_valid"}, 32'(qv_b), 1);
        chk({tag, "_q"},     32'(q_b), 32'(eq));
        chk({tag, "_last"},  32'(last_b), 32'(elast));
        chk({tag, "_none"},  32'(none_b), 0);
    endtask

    task automatic beat_c(input string tag, input int eq, input int elast);
        chk({tag, "_valid"}, 32'(qv_c), 1);
        chk({tag, "_q"},     32'(q_c), 32'(eq));
        chk({tag, "_last"},  32'(last_c), 32'(elast));
        chk({tag, "_none"},  32'(none_c), 0);
    endtask

    task automatic idle_a(input string tag);
        chk({tag, "_ready"}, 32'(rdy_a), 1);
        chk({tag, "_valid"}, 32'(qv_a), 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        data_a  = '0; data_b = '0; data_c = '0;
        valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
        qr_a    = 1'b1; qr_b = 1'b1; qr_c = 1'b1;

        // Reset values
        #12;
        chk("rst_valid_a", 32'(qv_a), 0);
        chk("rst_q_a",     32'(q_a), 0);
        chk("rst_last_a",  32'(last_a), 0);
        chk("rst_none_a",  32'(none_a), 0);
        chk("rst_valid_c", 32'(qv_c), 0);
        step();
        rst_n = 1'b1;
        step();
        idle_a("post_rst_a");
        chk("post_rst_ready_b", 32'(rdy_b), 1);

        // LSB-first 1010_0110 -> 1,2,5,7
        data_a = 8'b1010_0110; valid_a = 1'b1;
        step();
        valid_a = 1'b0; data_a = 8'hFF;
        beat_a("lsb_b0", 1, 0, 0); step();
        beat_a("lsb_b1", 2, 0, 0); step();
        beat_a("lsb_b2", 5, 0, 0); step();
        beat_a("lsb_b3", 7, 1, 0); step();
        idle_a("lsb_done");

        // MSB-first same vector -> 7,5,2,1
        data_b = 8'b1010_0110; valid_b = 1'b1;
        step();
        valid_b = 1'b0;
        beat_b("msb_b0", 7, 0); step();
        beat_b("msb_b1", 5, 0); step();
        beat_b("msb_b2", 2, 0); step();
        beat_b("msb_b3", 1, 1); step();
        chk("msb_done_ready", 32'(rdy_b), 1);
        chk("msb_done_valid", 32'(qv_b), 0);

        // All-zero vector -> single beat with q_none
        data_a = 8'h00; valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        beat_a("zero_b0", 0, 1, 1); step();
        idle_a("zero_done");

        // 0x81 with downstream stalled for three cycles on the first beat
        data_a = 8'h81; valid_a = 1'b1; qr_a = 1'b0;
        step();
        valid_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            beat_a("stall_hold", 0, 0, 0);
            step();
        end
        qr_a = 1'b1;
        beat_a("stall_b0", 0, 0, 0); step();
        beat_a("stall_b1", 7, 1, 0); step();
        idle_a("stall_done");

        // 0xFF interrupted by reset after the second beat
        data_a = 8'hFF; valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        beat_a("rst_mid_b0", 0, 0, 0); step();
        beat_a("rst_mid_b1", 1, 0, 0); step();
        beat_a("rst_mid_b2", 2, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(qv_a), 0);
        chk("rst_mid_q",     32'(q_a), 0);
        chk("rst_mid_last",  32'(last_a), 0);
        chk("rst_mid_none",  32'(none_a), 0);
        step();
        rst_n = 1'b1;
        step();
        idle_a("rst_rel0");
        step();
        idle_a("rst_rel1");

        // 13-bit 0x1001 -> 0,12 with valid_i toggling during emission
        data_c = 13'h1001; valid_c = 1'b1;
        step();
        data_c = 13'h1FFF; valid_c = 1'b0;
        beat_c("w13_b0", 0, 0);
        valid_c = 1'b1;
        step();
        beat_c("w13_b1", 12, 1);
        valid_c = 1'b0;
        step();
        chk("w13_done_ready", 32'(rdy_c), 1);
        chk("w13_done_valid", 32'(qv_c), 0);
        step();
        chk("w13_no_accept", 32'(qv_c), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
